// File: rtl/eaglesong_absorb_ctrl.sv
// Eaglesong sponge front end: XOR-absorbs 32-byte message chunks into the rate half of a
// 512-bit state, sequences an external permutation through start/done, and emits the rate as the hash.

module eaglesong_absorb_comb (
  input  logic [255:0] state_input,
  input  logic [255:0] input_val,
  input  logic [6:0]   input_length_bytes,
  input  logic [7:0]   absorb_round_num,
  output logic [255:0] state_output
);
  localparam logic [7:0] PAD_BYTE = 8'h06;

  logic [31:0] word;
  logic [6:0]  pos;
  logic        unused_round;

  // The round number is carried for the datapath interface; it does not alter the absorbed value.
  assign unused_round = ^absorb_round_num;

  // Each word packs its valid bytes MSB-first; the pad byte is shifted in at the first missing position
  // and bytes past it are not shifted in at all.
  always_comb begin
    state_output = state_input;
    word         = '0;
    pos          = '0;
    for (int j = 0; j < 8; j++) begin
      word = '0;
      for (int k = 0; k < 4; k++) begin
        pos = 7'(4 * j + k);
        if (pos < input_length_bytes) begin
          word = {word[23:0], input_val[8*(4*j+k) +: 8]};
        end else if (pos == input_length_bytes) begin
          word = {word[23:0], PAD_BYTE};
        end
      end
      state_output[255-32*j -: 32] = state_input[255-32*j -: 32] ^ word;
    end
  end
endmodule

module eaglesong_absorb_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [255:0] msg_data,
  input  logic [6:0]   msg_len,
  input  logic         msg_last,
  output logic         perm_start,
  output logic [511:0] perm_state_in,
  input  logic         perm_done,
  input  logic [511:0] perm_state_out,
  output logic         hash_valid,
  output logic [255:0] hash_out,
  output logic         err_len,
  output logic         busy
);
  localparam logic [6:0] CHUNK_BYTES = 7'd32;
  localparam logic [7:0] PAD_BYTE    = 8'h06;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_ACCEPT = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_PAD    = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  state_t       state, state_nx;
  logic [511:0] st, st_nx;
  logic [7:0]   chunk_cnt, cnt_nx;
  logic         pad_pend, pad_nx;
  logic         last_f, last_nx;
  logic         err_nx;
  logic         len_bad;
  logic [255:0] absorbed;

  eaglesong_absorb_comb u_absorb (
    .state_input        (st[511:256]),
    .input_val          (msg_data),
    .input_length_bytes (msg_len),
    .absorb_round_num   (chunk_cnt),
    .state_output       (absorbed)
  );

  // st only changes on handshake, perm_done, pad and clear, so it is stable for the whole
  // start..done window and can drive the permutation unit directly.
  assign perm_state_in = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    st_nx    = st;
    cnt_nx   = chunk_cnt;
    pad_nx   = pad_pend;
    last_nx  = last_f;
    err_nx   = 1'b0;
    len_bad  = (msg_len == 7'd0) || (msg_len > CHUNK_BYTES) ||
               ((msg_len != CHUNK_BYTES) && !msg_last);
    case (state)
      S_INIT: state_nx = S_ACCEPT;
      S_ACCEPT: begin
        if (msg_valid) begin
          if (len_bad) begin
            err_nx = 1'b1;
          end else begin
            st_nx    = {absorbed, st[255:0]};
            cnt_nx   = (chunk_cnt == 8'hFF) ? chunk_cnt : chunk_cnt + 8'd1;
            pad_nx   = msg_last && (msg_len == CHUNK_BYTES);
            last_nx  = msg_last;
            state_nx = S_START;
          end
        end
      end
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (perm_done) begin
          st_nx = perm_state_out;
          if (pad_pend)    state_nx = S_PAD;
          else if (last_f) state_nx = S_OUT;
          else             state_nx = S_ACCEPT;
        end
      end
      S_PAD: begin
        st_nx[511:504] = st[511:504] ^ PAD_BYTE;
        pad_nx         = 1'b0;
        state_nx       = S_START;
      end
      S_OUT: begin
        st_nx    = '0;
        cnt_nx   = '0;
        last_nx  = 1'b0;
        state_nx = S_ACCEPT;
      end
      default: state_nx = S_INIT;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= '0;
      chunk_cnt  <= '0;
      pad_pend   <= 1'b0;
      last_f     <= 1'b0;
      msg_ready  <= 1'b0;
      perm_start <= 1'b0;
      hash_valid <= 1'b0;
      hash_out   <= '0;
      err_len    <= 1'b0;
      busy       <= 1'b1;
    end else begin
      st         <= st_nx;
      chunk_cnt  <= cnt_nx;
      pad_pend   <= pad_nx;
      last_f     <= last_nx;
      msg_ready  <= (state_nx == S_ACCEPT);
      perm_start <= (state_nx == S_START);
      hash_valid <= (state_nx == S_OUT);
      err_len    <= err_nx;
      busy       <= (state_nx != S_ACCEPT);
      if (state_nx == S_OUT) hash_out <= st_nx[511:256];
    end
  end
endmodule

// File: tb/tb_eaglesong_absorb_ctrl.sv
// Bench for eaglesong_absorb_ctrl: directed vector table, hand-written corner sequences and
// randomized messages checked against a byte-level sponge model.

module tb_eaglesong_absorb_ctrl;
  localparam logic [255:0] HELLO_DATA = 256'h0A21646C726F77202C6F6C6C6548;
  localparam logic [255:0] HELLO_RATE = 256'h48656C6C6F2C20776F726C6400210A06_00000000000000000000000000000000;
  localparam logic [255:0] FULL_DATA  = 256'hF0076FEA59EB21788E3D74ACEB995CFDC2D1D6A5D36763D81583FDF3075FAB21;
  localparam logic [255:0] FULL_RATE  = 256'h21AB5F07F3FD8315D86367D3A5D6D1C2FD5C99EBAC743D8E7821EB59EA6F07F0;
  localparam logic [255:0] FULL_HASH  = 256'h27AB5F07F3FD8315D86367D3A5D6D1C2FD5C99EBAC743D8E7821EB59EA6F07F0;
  localparam logic [255:0] TWO_HASH   = 256'h69CE336B9CD1A362B7110BB7A5F7DBC4FD5C99EBAC743D8E7821EB59EA6F07F0;

  logic         clk = 1'b0;
  logic         reset;
  logic         msg_valid, msg_ready, msg_last;
  logic [255:0] msg_data;
  logic [6:0]   msg_len;
  logic         perm_start, perm_done;
  logic [511:0] perm_state_in, perm_state_out;
  logic         hash_valid, err_len, busy;
  logic [255:0] hash_out;

  eaglesong_absorb_ctrl dut (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .msg_len(msg_len), .msg_last(msg_last),
    .perm_start(perm_start), .perm_state_in(perm_state_in), .perm_done(perm_done),
    .perm_state_out(perm_state_out), .hash_valid(hash_valid), .hash_out(hash_out),
    .err_len(err_len), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] d;
    int           len;
    bit           last;
  } chunk_t;

  typedef struct {
    logic [255:0] d;
    int           len;
    bit           last;
    int           starts;
    int           errs;
    logic [255:0] first_rate;
    logic [255:0] hash;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int perm_mode = 0;
  int perm_lat = 2;
  chunk_t msg_q[$];
  vec_t   tbl[9];

  int           r_start, r_err, r_hash_n, r_hash_lat, r_ready_lat, r_done_k;
  bit           r_ready0, r_start0;
  logic [511:0] r_first_psi;
  logic [255:0] r_hash;

  task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_h(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Permutation model: mode 0 is the identity, mode 1 rotates by one word and XORs a constant.
  function automatic logic [511:0] perm_fn(input int mode, input logic [511:0] x);
    if (mode == 0) return x;
    return {x[479:0], x[511:480]} ^ {16{32'h9E3779B9}};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk_b({tag, "_ready"}, msg_ready, 1'b0);
    chk_b({tag, "_start"}, perm_start, 1'b0);
    chk_w({tag, "_psi"}, perm_state_in, '0);
    chk_b({tag, "_hvalid"}, hash_valid, 1'b0);
    chk_h({tag, "_hash"}, hash_out, '0);
    chk_b({tag, "_err"}, err_len, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b1);
  endtask

  // Plays the permutation unit after a handshake until the controller is ready again.
  task automatic service();
    bit pend = 1'b0;
    bit fin = 1'b0;
    int wn = 0;
    logic [511:0] cap = '0;
    r_start = 0; r_err = 0; r_hash_n = 0; r_hash_lat = -1; r_ready_lat = -1;
    r_done_k = -100; r_first_psi = '0; r_hash = '0;
    r_ready0 = msg_ready; r_start0 = perm_start;
    for (int k = 0; k < 400; k++) begin
      perm_done = 1'b0;
      if (err_len) r_err++;
      if (hash_valid) begin
        r_hash_n++;
        r_hash = hash_out;
        r_hash_lat = k - r_done_k;
      end
      if (perm_start) begin
        r_start++;
        cap = perm_state_in;
        if (r_start == 1) r_first_psi = cap;
        pend = 1'b1;
        wn = perm_lat;
      end else if (pend) begin
        wn--;
        if (wn <= 0) begin
          perm_done = 1'b1;
          perm_state_out = perm_fn(perm_mode, cap);
          pend = 1'b0;
          r_done_k = k;
        end
      end
      if (msg_ready && !pend) begin
        r_ready_lat = k - r_done_k;
        fin = 1'b1;
        break;
      end
      step();
    end
    perm_done = 1'b0;
    if (!fin) chk_b("service_timeout", msg_ready, 1'b1);
  endtask

  task automatic send_chunk(input logic [255:0] d, input int len, input bit last);
    int t = 0;
    while (!msg_ready && t < 100) begin
      step();
      t++;
    end
    if (!msg_ready) chk_b("ready_timeout", msg_ready, 1'b1);
    msg_valid = 1'b1;
    msg_data  = d;
    msg_len   = 7'(len);
    msg_last  = last;
    step();
    msg_valid = 1'b0;
    service();
  endtask

  // Reference sponge over msg_q: illegal chunks are skipped, each legal chunk's bytes are packed
  // MSB-first per word with 0x06 at the first missing byte, then the permutation is applied.
  function automatic void model(input int mode, output logic [255:0] h, output int starts,
                                output int errs, output int hashes);
    logic [31:0]  w[16];
    logic [511:0] s;
    logic [31:0]  acc;
    int           p, len;
    for (int i = 0; i < 16; i++) w[i] = '0;
    h = '0; starts = 0; errs = 0; hashes = 0;
    foreach (msg_q[c]) begin
      len = msg_q[c].len;
      if (len == 0 || len > 32 || (len != 32 && !msg_q[c].last)) begin
        errs++;
        continue;
      end
      for (int j = 0; j < 8; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
          p = 4 * j + k;
          if (p < len) acc = acc * 256 + 32'(msg_q[c].d[8*p +: 8]);
          else if (p == len) acc = acc * 256 + 32'h06;
        end
        w[j] = w[j] ^ acc;
      end
      for (int i = 0; i < 16; i++) s[511-32*i -: 32] = w[i];
      s = perm_fn(mode, s);
      starts++;
      if (msg_q[c].last && len == 32) begin
        s[511:480] = s[511:480] ^ 32'h06000000;
        s = perm_fn(mode, s);
        starts++;
      end
      for (int i = 0; i < 16; i++) w[i] = s[511-32*i -: 32];
      if (msg_q[c].last) begin
        h = s[511:256];
        hashes++;
        for (int i = 0; i < 16; i++) w[i] = '0;
      end
    end
  endfunction

  task automatic run_message(input string tag, input bit check_sat);
    int s = 0, e = 0, hn = 0;
    logic [255:0] hv = '0;
    logic [255:0] eh;
    int es, ee, ehn;
    model(perm_mode, eh, es, ee, ehn);
    foreach (msg_q[i]) begin
      if (check_sat && i == msg_q.size() - 1) chk_i({tag, "_cnt_sat"}, int'(dut.chunk_cnt), 255);
      send_chunk(msg_q[i].d, msg_q[i].len, msg_q[i].last);
      s += r_start;
      e += r_err;
      hn += r_hash_n;
      if (r_hash_n > 0) hv = r_hash;
    end
    chk_i({tag, "_starts"}, s, es);
    chk_i({tag, "_errs"}, e, ee);
    chk_i({tag, "_hashes"}, hn, ehn);
    chk_h({tag, "_hash"}, hv, eh);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached with the test still running");
    $fatal(1, "watchdog");
  end

  initial begin
    chunk_t ch;
    int nch, pick;

    tbl[0] = '{d: HELLO_DATA, len: 14, last: 1'b1, starts: 1, errs: 0, first_rate: HELLO_RATE, hash: HELLO_RATE};
    tbl[1] = '{d: FULL_DATA, len: 32, last: 1'b1, starts: 2, errs: 0, first_rate: FULL_RATE, hash: FULL_HASH};
    tbl[2] = '{d: HELLO_DATA, len: 0, last: 1'b1, starts: 0, errs: 1, first_rate: '0, hash: '0};
    tbl[3] = '{d: HELLO_DATA, len: 14, last: 1'b0, starts: 0, errs: 1, first_rate: '0, hash: '0};
    tbl[4] = '{d: FULL_DATA, len: 33, last: 1'b1, starts: 0, errs: 1, first_rate: '0, hash: '0};
    tbl[5] = '{d: HELLO_DATA, len: 14, last: 1'b1, starts: 1, errs: 0, first_rate: HELLO_RATE, hash: HELLO_RATE};
    tbl[6] = '{d: 256'hAB, len: 1, last: 1'b1, starts: 1, errs: 0,
               first_rate: {32'h0000AB06, 224'h0}, hash: {32'h0000AB06, 224'h0}};
    tbl[7] = '{d: 256'h44332211, len: 4, last: 1'b1, starts: 1, errs: 0,
               first_rate: {32'h11223344, 32'h00000006, 192'h0}, hash: {32'h11223344, 32'h00000006, 192'h0}};
    tbl[8] = '{d: '1, len: 31, last: 1'b1, starts: 1, errs: 0,
               first_rate: {{7{32'hFFFFFFFF}}, 32'hFFFFFF06}, hash: {{7{32'hFFFFFFFF}}, 32'hFFFFFF06}};

    reset = 1'b1; msg_valid = 1'b0; msg_data = '0; msg_len = '0; msg_last = 1'b0;
    perm_done = 1'b0; perm_state_out = '0;
    #3;
    chk_reset_vals("por");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk_b("ready_before_clock", msg_ready, 1'b0);
    step();
    chk_b("ready_after_release", msg_ready, 1'b1);
    chk_b("busy_idle", busy, 1'b0);

    // Directed single-chunk vectors from the idle state, identity permutation.
    for (int i = 0; i < 9; i++) begin
      perm_mode = 0; perm_lat = 2;
      send_chunk(tbl[i].d, tbl[i].len, tbl[i].last);
      chk_i("tbl_starts", r_start, tbl[i].starts);
      chk_i("tbl_errs", r_err, tbl[i].errs);
      chk_i("tbl_hashes", r_hash_n, (tbl[i].starts > 0) ? 1 : 0);
      if (tbl[i].starts > 0) begin
        chk_b("tbl_start_next_cycle", r_start0, 1'b1);
        chk_w("tbl_first_psi", r_first_psi, {tbl[i].first_rate, 256'h0});
        chk_h("tbl_hash", r_hash, tbl[i].hash);
        chk_i("tbl_hash_lat", r_hash_lat, 1);
        chk_i("tbl_ready_lat", r_ready_lat, 2);
      end else begin
        chk_b("tbl_ready_held", r_ready0, 1'b1);
        chk_i("tbl_cnt_held", int'(dut.chunk_cnt), 0);
      end
    end

    // Two-chunk message: full non-last chunk then Hello.
    send_chunk(FULL_DATA, 32, 1'b0);
    chk_i("two_first_starts", r_start, 1);
    chk_i("two_first_hashes", r_hash_n, 0);
    chk_i("two_ready_lat", r_ready_lat, 1);
    chk_i("two_round_num", int'(dut.chunk_cnt), 1);
    send_chunk(HELLO_DATA, 14, 1'b1);
    chk_i("two_second_starts", r_start, 1);
    chk_h("two_hash", r_hash, TWO_HASH);
    chk_i("two_cnt_cleared", int'(dut.chunk_cnt), 0);

    // Reset while waiting for the permutation; a perm_done right after release must be ignored.
    msg_valid = 1'b1; msg_data = HELLO_DATA; msg_len = 7'd14; msg_last = 1'b1;
    step();
    msg_valid = 1'b0;
    chk_b("rst_start", perm_start, 1'b1);
    step(); step();
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    step(); step();
    reset = 1'b0;
    perm_done = 1'b1; perm_state_out = {16{32'hDEADBEEF}};
    chk_b("rst_ready_pre", msg_ready, 1'b0);
    step();
    perm_done = 1'b0;
    chk_b("rst_ready", msg_ready, 1'b1);
    chk_w("rst_psi", perm_state_in, '0);
    chk_b("rst_busy", busy, 1'b0);
    step();
    chk_b("rst_no_start", perm_start, 1'b0);
    chk_b("rst_no_hash", hash_valid, 1'b0);
    send_chunk(HELLO_DATA, 14, 1'b1);
    chk_h("rst_then_hello", r_hash, HELLO_RATE);

    // perm_done outside S_WAIT: while idle, and during the S_START cycle.
    perm_done = 1'b1; perm_state_out = {16{32'hA5A5A5A5}};
    step();
    perm_done = 1'b0;
    chk_w("early_idle_psi", perm_state_in, '0);
    chk_b("early_idle_ready", msg_ready, 1'b1);
    chk_b("early_idle_busy", busy, 1'b0);
    msg_valid = 1'b1; msg_data = HELLO_DATA; msg_len = 7'd14; msg_last = 1'b1;
    step();
    msg_valid = 1'b0;
    chk_b("early_start", perm_start, 1'b1);
    perm_done = 1'b1; perm_state_out = {16{32'h5A5A5A5A}};
    step();
    perm_done = 1'b0;
    chk_w("early_start_psi", perm_state_in, {HELLO_RATE, 256'h0});
    chk_b("early_start_busy", busy, 1'b1);
    chk_b("early_start_nohash", hash_valid, 1'b0);
    step();
    perm_done = 1'b1; perm_state_out = perm_state_in;
    step();
    perm_done = 1'b0;
    chk_b("early_hvalid", hash_valid, 1'b1);
    chk_h("early_hash", hash_out, HELLO_RATE);
    step();
    chk_b("early_ready", msg_ready, 1'b1);

    // chunk_cnt saturation over a long message.
    msg_q.delete();
    for (int c = 0; c < 260; c++) begin
      ch.d = rand256(); ch.len = 32; ch.last = 1'b0;
      msg_q.push_back(ch);
    end
    ch.d = HELLO_DATA; ch.len = 14; ch.last = 1'b1;
    msg_q.push_back(ch);
    perm_mode = 1; perm_lat = 1;
    run_message("sat", 1'b1);

    // Randomized messages with occasional illegal chunks, both permutation models, varied latency.
    for (int m = 0; m < 40; m++) begin
      msg_q.delete();
      nch = int'($urandom_range(1, 4));
      for (int c = 0; c < nch; c++) begin
        if ($urandom_range(0, 4) == 0) begin
          ch.d = rand256();
          pick = int'($urandom_range(0, 2));
          if (pick == 0) begin
            ch.len = 0; ch.last = 1'($urandom_range(0, 1));
          end else if (pick == 1) begin
            ch.len = int'($urandom_range(33, 127)); ch.last = 1'($urandom_range(0, 1));
          end else begin
            ch.len = int'($urandom_range(1, 31)); ch.last = 1'b0;
          end
          msg_q.push_back(ch);
        end
        ch.d = rand256();
        ch.last = (c == nch - 1);
        ch.len = 32;
        if (ch.last && $urandom_range(0, 2) != 0) ch.len = int'($urandom_range(1, 32));
        msg_q.push_back(ch);
      end
      perm_mode = int'($urandom_range(0, 1));
      perm_lat = int'($urandom_range(1, 5));
      run_message("rand", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/eaglesong_absorb_ctrl.md
# eaglesong_absorb_ctrl

Sequencer for the Eaglesong sponge front end. It accepts a message as a stream of 32-byte chunks, drives the combinational absorb datapath (`eaglesong_absorb_comb`, instantiated inside) on the rate half of a 512-bit state register, and hands each absorbed state to an external permutation unit through a start/done handshake. After the last chunk and any padding, it presents the 256-bit rate as the hash.

## Interface
- No parameters. Rate is 8 words, capacity is 8 words and word width is 32; all are fixed.
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `msg_valid`  in  1  — a chunk is offered.
- `msg_ready`  out  1  — the controller can accept a chunk.
- `msg_data`  in  256  — chunk bytes. Byte 0 is in bits [7:0].
- `msg_len`  in  7  — number of valid bytes: exactly 32 on a non-last chunk, 1..32 on the last chunk.
- `msg_last`  in  1  — this chunk ends the message.
- `perm_start`  out  1  — one-cycle request to the permutation unit.
- `perm_state_in`  out  512  — state words 0..15, with word 0 in bits [511:480]. Stable from `perm_start` until `perm_done`.
- `perm_done`  in  1  — one-cycle pulse; `perm_state_out` is valid in that cycle.
- `perm_state_out`  in  512  — permuted state, same word order as `perm_state_in`.
- `hash_valid`  out  1  — one-cycle pulse marking the hash.
- `hash_out`  out  256  — state words 0..7, with word 0 in bits [255:224]. Held until the next `hash_valid`.
- `err_len`  out  1  — one-cycle pulse on an illegal `msg_len`.
- `busy`  out  1  — high whenever the FSM is not in S_ACCEPT.

## Operation
- The state register `st[0..15]` is all zero after reset and after each hash is output.
- `chunk_cnt` is 8 bits, saturates at 255, and drives `absorb_round_num` of the comb block.
- Comb block connections:
  - `state_input` = `st[0..7]`
  - `input_val` = `msg_data`
  - `input_length_bytes` = `msg_len`
- The comb block appends the 0x06 pad byte itself when `msg_len` < 32.
- FSM states:
  - **S_INIT**: entered on reset. Moves to S_ACCEPT on the next clock.
  - **S_ACCEPT**: `msg_ready`=1. On handshake with a legal length:
    - `st[0..7]` <= comb `state_output`
    - `chunk_cnt`++
    - `pad_pend` <= `msg_last` && `msg_len`==32
    - `last_f` <= `msg_last`
    - Go to S_START.
  - **S_START**: `perm_start`=1 for exactly one cycle, then go to S_WAIT.
  - **S_WAIT**: on `perm_done`, `st` <= `perm_state_out`. Then:
    - if `pad_pend`, go to S_PAD;
    - else if `last_f`, go to S_OUT;
    - else go to S_ACCEPT.
  - **S_PAD**: `st[0][31:24]` ^= 0x06, clear `pad_pend`, go to S_START. The comb block is not used in this state.
  - **S_OUT**: `hash_out` <= `st[0..7]` and `hash_valid`=1. Clear `st` and `chunk_cnt`, clear `last_f`, go to S_ACCEPT.
- Illegal chunk: `msg_len`==0, or `msg_len`>32, or `msg_len`≠32 with `msg_last`=0.
  - The chunk is still accepted (handshake completes) and `err_len` pulses for one cycle.
  - `st`, `chunk_cnt` and the FSM state are unchanged.
- `perm_done` is ignored outside S_WAIT.

## Timing
- All outputs are registered.
- Reset values: `msg_ready`=0, `perm_start`=0, `perm_state_in`=0, `hash_valid`=0, `hash_out`=0, `err_len`=0, `busy`=1 (S_INIT). After reset release, `msg_ready` rises on the first clock.
- For a handshake at edge T:
  - `perm_start` is high in cycle T+1.
  - The permutation unit must return `perm_done` no earlier than T+2.
- For `perm_done` at edge D:
  - Non-last chunk: `msg_ready`=1 from D+1.
  - Last chunk with `msg_len`<32: `hash_valid` at D+1, `msg_ready` again at D+2.
  - Last chunk with `msg_len`==32: S_PAD at D+1, second `perm_start` at D+2, `hash_valid` one cycle after the second `perm_done`.
- Minimum throughput: one chunk per (permutation latency + 2) cycles.
- `msg_ready` is 0 from the cycle after a handshake until the FSM returns to S_ACCEPT. Back-to-back handshakes are therefore impossible.
- Reset mid-operation (any state): everything returns to its reset values asynchronously. Any in-flight `perm_done` after release is ignored. The permutation unit shares `reset`.

## Test plan
Permutation model for all tests: identity with 3-cycle latency.
1. **Single short chunk.** Hello chunk: `msg_data`=256'h0A21646C726F77202C6F6C6C6548, `msg_len`=14, `msg_last`=1.
   - `perm_state_in` words 0..3 = 48656C6C 6F2C2077 6F726C64 00210A06; all other words 0.
   - `absorb_round_num`=0.
   - `hash_out`=128'h48656C6C6F2C20776F726C6400210A06 followed by 128 zero bits.
   - `hash_valid` arrives 1 cycle after `perm_done`.
2. **Full last chunk with padding.** `msg_data`=256'hF0076FEA59EB21788E3D74ACEB995CFDC2D1D6A5D36763D81583FDF3075FAB21, `msg_len`=32, `msg_last`=1.
   - First `perm_state_in` words 0..7 = 21AB5F07 F3FD8315 D86367D3 A5D6D1C2 FD5C99EB AC743D8E 7821EB59 EA6F07F0.
   - A second `perm_start` occurs; `hash_out` word 0 = 27AB5F07, other words unchanged.
3. **Two chunks.** The 32-byte chunk of test 2 with `msg_last`=0, then the Hello chunk with `msg_last`=1.
   - Second absorb uses `absorb_round_num`=1.
   - `hash_out` = 69CE336B 9CD1A362 B7110BB7 A5F7DBC4 FD5C99EB AC743D8E 7821EB59 EA6F07F0.
4. **Illegal lengths.** `msg_len`=0 with `msg_last`=1, then `msg_len`=14 with `msg_last`=0.
   - `err_len` pulses twice.
   - No `perm_start`, `chunk_cnt` stays 0, and `msg_ready` stays 1.
   - A following legal Hello chunk still yields the hash of test 1.
5. **Reset during S_WAIT.** Assert `reset` two cycles after `perm_start`, and let the model's `perm_done` arrive after release.
   - All outputs go to their reset values; the late `perm_done` is ignored.
   - `msg_ready`=1 one cycle after release.
   - A subsequent Hello chunk yields the hash of test 1.
6. **Early `perm_done`.** Pulse `perm_done` while in S_ACCEPT or S_START.
   - `st` is unchanged and there is no state transition.
